csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR storage stage directly downstream of the CSR write-value mux.
- Accepts the already-computed 64-bit new CSR value plus a write strobe, and supplies the old CSR value for rd writeback.
- Also owns trap entry, mret return, the cycle/instret counters and timer-interrupt pending detection; drives the PC redirect to the fetch stage.

Parameters:
- MTVEC_RESET, 64'h0, reset value of mtvec.
- HART_ID, 64'h0, constant returned for mhartid.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  12  CSR read address (from instruction imm[11:0]).
- rdata  out  64  current value at raddr; combinational.
- illegal_access  out  1  raddr is unimplemented, or we=1 with waddr read-only or unimplemented.
- we  in  1  CSR write strobe; low when the mux selects "no write".
- waddr  in  12  CSR write address.
- wdata  in  64  new value from the CSR write-value mux.
- trap_valid  in  1  exception or interrupt taken this cycle.
- trap_pc  in  64  PC of the faulting or interrupted instruction.
- trap_cause  in  64  mcause value; bit63 = interrupt.
- trap_tval  in  64  mtval value.
- mret  in  1  mret retiring this cycle.
- instret_inc  in  1  one instruction retired this cycle.
- timer_irq  in  1  machine timer interrupt line, asynchronous to pipeline.
- redirect_valid  out  1  PC redirect request; combinational.
- redirect_pc  out  64  redirect target.
- irq_pending  out  1  enabled machine timer interrupt pending; registered-derived.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE bit3, MPIE bit7 and MPP[12:11] exist; MPP reads constant 2'b11; all other bits read 0.
  - mie 0x304: only bit7 (MTIE) is writable.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; bit7 (MTIP) only.
  - mcycle 0xB00.
  - minstret 0xB02.
  - mhartid 0xF14: read-only.
- Reset values:
  - mstatus = 64'h1800; mtvec = MTIP-independent MTVEC_RESET.
  - All other storage = 0.
  - Outputs: redirect_valid=0, irq_pending=0, illegal_access=0.
- Read: combinational from raddr. A same-cycle write is not forwarded; rdata shows the pre-edge value.
- Unimplemented or read-only access:
  - Unimplemented raddr → rdata=0, illegal_access=1.
  - Write to unimplemented or read-only address → ignored, illegal_access=1.
- Write field rules:
  - mtvec: bit1 forced 0 (MODE is 0 = direct or 1 = vectored).
  - mepc: bits[1:0] forced 0.
  - Writes to read-only fields are ignored.
- Per-cycle priority, highest first: trap_valid > mret > we.
  - A lower-priority event in the same cycle is dropped entirely, including its write.
  - Counters still update, subject to the counter rules below.
- Trap entry (at clock edge):
  - mepc ← {trap_pc[63:2],2'b00}; mcause ← trap_cause; mtval ← trap_tval.
  - MPIE ← MIE; MIE ← 0.
  - redirect_valid=1 in the same cycle.
  - redirect_pc = {mtvec[63:2],2'b00}, plus 4*trap_cause[5:0] only when mtvec[0]=1 and trap_cause[63]=1.
- mret (at clock edge):
  - MIE ← MPIE; MPIE ← 1.
  - redirect_valid=1 in the same cycle; redirect_pc = current mepc.
- mcycle:
  - +1 every cycle, wrapping at 2^64.
  - A CSR write to mcycle in a cycle loads wdata instead of incrementing.
- minstret:
  - +1 when instret_inc=1, wrapping.
  - A write to minstret loads wdata, and the increment in that cycle is lost.
- timer_irq:
  - Two-flop synchronizer; mip.MTIP = second flop.
  - MTIP reflects timer_irq 2 cycles after the line changes.
- irq_pending = mstatus.MIE & mie[7] & mip[7], computed from registered state only.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk; an in-flight trap or redirect is discarded.

Decomposition:
- Shared package csr_pkg:
  - 12-bit address constants for each CSR.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - MTIE/MTIP bit index 7.
  - Cause constants (e.g. CAUSE_M_TIMER = 64'h8000_0000_0000_0007, CAUSE_ILLEGAL = 2, CAUSE_ECALL_M = 11).
- One natural sub-module: csr_counter, a 64-bit wrapping counter with increment enable and write-load override, instantiated for mcycle and minstret.

Test Plan:
- Reset, then read each implemented address → mstatus=0x1800, mhartid=HART_ID, others 0 except mcycle; mcycle reads 3 after 3 clocks.
- we=1 to waddr=0x305, wdata=0x8000_0003 → mtvec reads 0x8000_0001; we=1 to 0x341, wdata=0x1007 → mepc reads 0x1004.
- Set MIE=1, then trap_valid with trap_pc=0x2002, trap_cause=2, trap_tval=0xdead:
  - Same cycle: redirect_valid=1, redirect_pc=mtvec base.
  - Next cycle: mepc=0x2000, mcause=2, mtval=0xdead, MIE=0, MPIE=1.
- Set mtvec=0x100|1, MIE=1, mie=0x80, raise timer_irq:
  - mip=0x80 after 2 cycles; irq_pending=1.
  - trap with cause 0x8000…0007 → redirect_pc=0x11C.
- mret after the trap → redirect_pc=mepc; MIE=1, MPIE=1 next cycle. trap_valid, mret and we to mscratch in the same cycle → only the trap takes effect; mscratch is unchanged.
- Write minstret=0xFFFF_FFFF_FFFF_FFFF, then instret_inc=1 → reads 0 (wrap). Read 0x7C0 → rdata=0, illegal_access=1. Assert rst mid-run → mcycle=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR block.
//   - 12-bit CSR address constants
//   - mstatus field positions and reset value
//   - MTIE/MTIP bit index
//   - common mcause values
//   - address decode helpers (implemented / writable)
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MPP is hard-wired to machine mode, so it is part of every mstatus read.
  localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;

  // Shared index of MTIE (in mie) and MTIP (in mip).
  localparam int MTIX_BIT = 7;

  localparam logic [63:0] CAUSE_M_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // mip and mhartid are implemented but read-only.
  function automatic logic csr_writable(input logic [11:0] addr);
    return csr_implemented(addr) && (addr != CSR_MIP) && (addr != CSR_MHARTID);
  endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: 64-bit wrapping counter with increment enable and a load
// override. A load in a cycle wins over (and discards) that cycle's increment.
//   clk, rst      : clock, asynchronous active-high reset (count -> 0)
//   inc_i         : add one at the next edge
//   load_i        : load load_val_i at the next edge
//   load_val_i    : value to load
//   count_o       : current count
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage, trap entry / mret return, cycle and
// instret counters, and timer-interrupt pending detection.
//   clk, rst        : clock, asynchronous active-high reset
//   raddr / rdata   : combinational CSR read (no same-cycle write forwarding)
//   illegal_access  : unimplemented raddr, or write to read-only/unimplemented
//   we/waddr/wdata  : CSR write (value already computed by the write mux)
//   trap_*          : trap entry request and its mepc/mcause/mtval payload
//   mret            : mret retiring this cycle
//   instret_inc     : one instruction retired this cycle
//   timer_irq       : asynchronous machine timer line
//   redirect_*      : PC redirect to fetch
//   irq_pending     : enabled, pending machine timer interrupt
//
// Redirect handshake: redirect_valid is a one-cycle pulse with no ready; fetch
// must take redirect_pc in the same cycle it is high. It is raised in the cycle
// trap_valid or mret is presented and is forced low while rst is asserted.
//
// Event priority per cycle: trap_valid > mret > we. A lower-priority event is
// dropped entirely; counters keep counting regardless.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h0,
  parameter logic [63:0] HART_ID     = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raddr,
  output logic [63:0] rdata,
  output logic        illegal_access,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [63:0] wdata,
  input  logic        trap_valid,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_tval,
  input  logic        mret,
  input  logic        instret_inc,
  input  logic        timer_irq,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        irq_pending
);

  logic        mie_q, mie_d;     // mstatus.MIE
  logic        mpie_q, mpie_d;   // mstatus.MPIE
  logic        mtie_q, mtie_d;   // mie.MTIE
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic        tmr_sync_q;       // first synchronizer flop
  logic        mtip_q;           // second synchronizer flop = mip.MTIP

  logic [63:0] mcycle, minstret;
  logic        wr_en;
  logic [63:0] trap_target;
  logic [63:0] mstatus_rd;

  // A CSR write only lands when no trap or mret claims the cycle.
  assign wr_en = we & ~trap_valid & ~mret & csr_writable(waddr);

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d   = {trap_pc[63:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (waddr)
        CSR_MSTATUS: begin
          mie_d  = wdata[MSTATUS_MIE];
          mpie_d = wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mtie_d     = wdata[MTIX_BIT];
        // Bit1 is reserved in MODE; only direct (0) and vectored (1) exist.
        CSR_MTVEC:    mtvec_d    = {wdata[63:2], 1'b0, wdata[0]};
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[63:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      tmr_sync_q <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      tmr_sync_q <= timer_irq;
      mtip_q     <= tmr_sync_q;
    end
  end

  csr_counter u_mcycle (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (1'b1),
    .load_i     (wr_en && (waddr == CSR_MCYCLE)),
    .load_val_i (wdata),
    .count_o    (mcycle)
  );

  csr_counter u_minstret (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (instret_inc),
    .load_i     (wr_en && (waddr == CSR_MINSTRET)),
    .load_val_i (wdata),
    .count_o    (minstret)
  );

  always_comb begin
    mstatus_rd               = MSTATUS_RESET;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MIE:      rdata[MTIX_BIT] = mtie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata[MTIX_BIT] = mtip_q;
      CSR_MCYCLE:   rdata = mcycle;
      CSR_MINSTRET: rdata = minstret;
      CSR_MHARTID:  rdata = HART_ID;
      default:      rdata = '0;
    endcase
  end

  assign illegal_access = ~rst & (~csr_implemented(raddr) | (we & ~csr_writable(waddr)));

  // Vectored mode offsets only interrupts; exceptions always go to the base.
  always_comb begin
    trap_target = {mtvec_q[63:2], 2'b00};
    if (mtvec_q[0] && trap_cause[63]) begin
      trap_target = trap_target + {56'b0, trap_cause[5:0], 2'b00};
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (trap_valid) begin
      redirect_pc = trap_target;
    end else if (mret) begin
      redirect_pc = mepc_q;
    end
  end

  assign redirect_valid = ~rst & (trap_valid | mret);
  assign irq_pending    = mie_q & mtie_q & mtip_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed walk-through followed by randomized traffic,
// checked against a behavioural model through an expected-value queue.
module tb_csr_regfile;
  import csr_pkg::*;

  localparam logic [63:0] P_MTVEC = 64'h0000_0000_0000_0400;
  localparam logic [63:0] P_HART  = 64'h0000_0000_0000_0005;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] raddr, waddr;
  logic [63:0] rdata, wdata, trap_pc, trap_cause, trap_tval, redirect_pc;
  logic        illegal_access, we, trap_valid, mret, instret_inc, timer_irq;
  logic        redirect_valid, irq_pending;

  always #5 clk = ~clk;

  csr_regfile #(.MTVEC_RESET(P_MTVEC), .HART_ID(P_HART)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
    .illegal_access(illegal_access), .we(we), .waddr(waddr), .wdata(wdata),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .mret(mret), .instret_inc(instret_inc),
    .timer_irq(timer_irq), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .irq_pending(irq_pending)
  );

  // ---------------- reference model ----------------
  logic [11:0] addr_pool[14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                 12'hF14, 12'h7C0, 12'h301, 12'hF11};
  localparam int N_IMPL = 11;  // first N_IMPL pool entries are implemented

  bit          m_mie, m_mpie, m_mtie;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;
  bit          tmr_hist[$];    // timer_irq value seen at the last two edges

  function automatic bit is_impl(input logic [11:0] a);
    for (int i = 0; i < N_IMPL; i++) if (addr_pool[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_wr(input logic [11:0] a);
    return is_impl(a) && a != 12'h344 && a != 12'hF14;
  endfunction

  // MTIP is the timer line as it stood two edges ago.
  function automatic bit m_mtip();
    return (tmr_hist.size() == 2) ? tmr_hist[0] : 1'b0;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (64'(m_mpie) * 128) + (64'(m_mie) * 8);
      12'h304: return 64'(m_mtie) * 128;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 64'(m_mtip()) * 128;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return P_HART;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_trap_target();
    logic [63:0] t;
    t = m_mtvec & ~64'h3;
    if (m_mtvec[0] && trap_cause[63]) t = t + 64'(trap_cause[5:0]) * 4;
    return t;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0;
    m_mtvec = P_MTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mcycle = 0; m_minstret = 0;
    tmr_hist.delete();
  endtask

  // Applies one clock edge worth of the currently driven inputs.
  task automatic model_update();
    bit          wr, old_mie;
    logic [63:0] nc, ni;
    wr = we && !trap_valid && !mret && is_wr(waddr);
    nc = m_mcycle + 1;
    ni = m_minstret + 64'(instret_inc);
    if (trap_valid) begin
      m_mepc = trap_pc & ~64'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret) begin
      old_mie = m_mpie; m_mpie = 1; m_mie = old_mie;
    end else if (wr) begin
      case (waddr)
        12'h300: begin m_mie = wdata[3]; m_mpie = wdata[7]; end
        12'h304: m_mtie = wdata[7];
        12'h305: m_mtvec = wdata & ~64'h2;
        12'h340: m_mscratch = wdata;
        12'h341: m_mepc = wdata & ~64'h3;
        12'h342: m_mcause = wdata;
        12'h343: m_mtval = wdata;
        12'hB00: nc = wdata;
        12'hB02: ni = wdata;
        default: ;
      endcase
    end
    m_mcycle = nc; m_minstret = ni;
    tmr_hist.push_back(timer_irq);
    if (tmr_hist.size() > 2) void'(tmr_hist.pop_front());
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic expect_out(input int sel, input logic [63:0] v, input string nm);
    exp_q.push_back(v); sel_q.push_back(sel); name_q.push_back(nm);
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0: return rdata;
      1: return 64'(illegal_access);
      2: return 64'(redirect_valid);
      3: return redirect_pc;
      default: return 64'(irq_pending);
    endcase
  endfunction

  // Monitor: everything queued for a cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [63:0] v, o;
      int          s;
      string       nm;
      v = exp_q.pop_front(); s = sel_q.pop_front(); nm = name_q.pop_front();
      o = observe(s);
      n_cmp++;
      if (o !== v) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h expected %h", nm, $time, o, v);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_idle();
    we = 0; waddr = 12'h300; wdata = 0; trap_valid = 0; trap_pc = 0;
    trap_cause = 0; trap_tval = 0; mret = 0; instret_inc = 0;
  endtask

  task automatic push_checks();
    bit rv;
    expect_out(0, m_read(raddr), $sformatf("rdata[%h]", raddr));
    expect_out(1, 64'(!is_impl(raddr) || (we && !is_wr(waddr))), "illegal_access");
    rv = trap_valid || mret;
    expect_out(2, 64'(rv), "redirect_valid");
    if (rv) expect_out(3, trap_valid ? m_trap_target() : m_mepc, "redirect_pc");
    expect_out(4, 64'(m_mie && m_mtie && m_mtip()), "irq_pending");
  endtask

  // Called at posedge+1: queue expectations for the current inputs, then
  // take the edge and advance the model.
  task automatic step();
    push_checks();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [63:0] v);
    we = 1; waddr = a; wdata = v; step(); set_idle();
  endtask

  task automatic rd_csr(input logic [11:0] a);
    raddr = a; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; raddr = 12'h300; timer_irq = 0; set_idle();
    repeat (2) @(posedge clk);
    #1; rst = 0; model_reset();

    // Reset values of every implemented CSR (mcycle keeps counting meanwhile).
    for (int i = 0; i < N_IMPL; i++) rd_csr(addr_pool[i]);
    rd_csr(12'hB00);

    // Field masking on mtvec and mepc.
    wr_csr(12'h305, 64'h8000_0003); rd_csr(12'h305);
    wr_csr(12'h341, 64'h1007);      rd_csr(12'h341);

    // Exception trap with MIE set.
    wr_csr(12'h300, 64'h8);
    trap_valid = 1; trap_pc = 64'h2002; trap_cause = CAUSE_ILLEGAL;
    trap_tval = 64'hdead; raddr = 12'h300;
    step(); set_idle();
    rd_csr(12'h341); rd_csr(12'h342); rd_csr(12'h343); rd_csr(12'h300);

    // Vectored timer interrupt.
    wr_csr(12'h305, 64'h101); wr_csr(12'h300, 64'h8); wr_csr(12'h304, 64'h80);
    timer_irq = 1;
    rd_csr(12'h344); rd_csr(12'h344); rd_csr(12'h344);
    trap_valid = 1; trap_pc = 64'h3000; trap_cause = CAUSE_M_TIMER; trap_tval = 0;
    step(); set_idle();
    rd_csr(12'h300);

    // mret, then all three events at once.
    mret = 1; step(); set_idle();
    rd_csr(12'h300);
    wr_csr(12'h340, 64'h1234_5678);
    trap_valid = 1; trap_pc = 64'h4004; trap_cause = CAUSE_ECALL_M; trap_tval = 64'h7;
    mret = 1; we = 1; waddr = 12'h340; wdata = 64'hFFFF_0000_AAAA_5555;
    step(); set_idle();
    rd_csr(12'h340); rd_csr(12'h341); rd_csr(12'h342);

    // minstret wrap, unimplemented address.
    wr_csr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    instret_inc = 1; raddr = 12'hB02; step(); set_idle();
    rd_csr(12'hB02);
    rd_csr(12'h7C0);
    we = 1; waddr = 12'hF14; wdata = 64'h99; raddr = 12'h300; step(); set_idle();
    rd_csr(12'hF14);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      raddr = addr_pool[$urandom_range(13, 0)];
      we = ($urandom_range(1, 0) == 1);
      waddr = addr_pool[$urandom_range(13, 0)];
      wdata = {$urandom, $urandom};
      trap_valid = ($urandom_range(15, 0) == 0);
      trap_pc = {$urandom, $urandom};
      trap_cause = {$urandom, $urandom};
      trap_tval = {$urandom, $urandom};
      mret = ($urandom_range(15, 0) == 0);
      instret_inc = ($urandom_range(1, 0) == 1);
      if ($urandom_range(19, 0) == 0) timer_irq = ~timer_irq;
      step();
    end
    set_idle();

    // Asynchronous reset in the middle of a cycle with a trap in flight.
    raddr = 12'hB00; trap_valid = 1; trap_pc = 64'h8000;
    #2; rst = 1; #1;
    expect_out(0, 64'h0, "rdata_async_rst");
    expect_out(2, 64'h0, "redirect_valid_rst");
    expect_out(1, 64'h0, "illegal_rst");
    expect_out(4, 64'h0, "irq_pending_rst");
    @(posedge clk); #1;
    rst = 0; set_idle(); timer_irq = 0; model_reset();
    rd_csr(12'h300); rd_csr(12'h305); rd_csr(12'hB00); rd_csr(12'hB02);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
